present_player_pipe: RTL

Parametrised, pipelined PRESENT bit-permutation (pLayer) engine with valid/ready handshakes. Supports forward permutation for encryption, inverse permutation for decryption, and bypass, selected per beat. Width generalises the 64-bit PRESENT layer to any multiple of 4. Sits between the sBox layer and the round-key adder in the round datapath, and decouples them with an elastic pipeline of configurable depth.

---
 rtl/present_player_pipe.sv | 109 ++++++++++
 1 files changed

// File: rtl/present_player_pipe.sv
// PRESENT pLayer engine: per-beat forward/inverse/bypass bit permutation feeding an
// elastic valid/ready pipeline of LATENCY register stages.
module present_player_pipe #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       mode_o,
  output logic             busy_o
);

  localparam int unsigned Msb = WIDTH - 1;

  if (WIDTH < 8 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("present_player_pipe: WIDTH must be a multiple of 4 and at least 8");
  end
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("present_player_pipe: LATENCY must be in 1..4");
  end

  logic [WIDTH-1:0] fwd_perm;
  logic [WIDTH-1:0] inv_perm;
  logic [WIDTH-1:0] perm;

  // Pure wiring: every source bit has a fixed destination in each direction.
  for (genvar i = 0; i < WIDTH; i++) begin : g_perm
    localparam int unsigned FwdDst = (i == Msb) ? Msb : (i * (WIDTH / 4)) % Msb;
    localparam int unsigned InvDst = (i == Msb) ? Msb : (4 * i) % Msb;
    assign fwd_perm[FwdDst] = data_i[i];
    assign inv_perm[InvDst] = data_i[i];
  end

  always_comb begin
    if (mode_i[1])      perm = data_i;
    else if (mode_i[0]) perm = inv_perm;
    else                perm = fwd_perm;
  end

  logic [LATENCY-1:0] v_q;
  logic [LATENCY-1:0] adv;
  logic [LATENCY-1:0] ld;
  logic [LATENCY-1:0] up_v;
  logic [1:0]         mode_q  [LATENCY];
  logic [WIDTH-1:0]   data_q  [LATENCY];
  logic [1:0]         up_mode [LATENCY];
  logic [WIDTH-1:0]   up_data [LATENCY];

  always_comb begin
    logic drain;
    drain = 1'b0;
    adv   = '0;
    ld    = '0;
    for (int k = 0; k < LATENCY; k++) begin
      // Stage k may advance if the sink drains or any later stage holds a hole.
      drain = out_ready_i;
      for (int j = k + 1; j < LATENCY; j++) drain = drain | ~v_q[j];
      adv[k] = drain;
      ld[k]  = ~v_q[k] | drain;
    end
  end

  always_comb begin
    up_v       = '0;
    up_v[0]    = in_valid_i;
    up_mode[0] = mode_i;
    up_data[0] = perm;
    for (int k = 1; k < LATENCY; k++) begin
      up_v[k]    = v_q[k-1];
      up_mode[k] = mode_q[k-1];
      up_data[k] = data_q[k-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        mode_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LATENCY; k++) begin
        if (ld[k]) begin
          v_q[k] <= up_v[k];
          // Bubbles move only the valid bit; payload keeps its last value.
          if (up_v[k]) begin
            mode_q[k] <= up_mode[k];
            data_q[k] <= up_data[k];
          end
        end
      end
    end
  end

  assign in_ready_o  = ld[0];
  assign out_valid_o = v_q[LATENCY-1];
  assign data_o      = data_q[LATENCY-1];
  assign mode_o      = mode_q[LATENCY-1];
  assign busy_o      = |v_q;

endmodule
